// File: rtl/peripheral_apb42ahb3_pkg.sv
// Shared encodings, FSM state type and APB-to-AHB protection mapping
// for the APB4-to-AHB3-Lite bridge.
package peripheral_apb42ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // PPROT[2] is "instruction", so data access is its inverse; PPROT[1] has no AHB counterpart
    function automatic logic [3:0] hprot_map(input logic [2:0] pprot);
        return {2'b00, pprot[0], ~pprot[2]};
    endfunction

endpackage

// File: rtl/peripheral_apb42ahb3_strb_decode.sv
// Maps APB write strobes to an AHB transfer size and byte offset;
// reads are always full words at offset 0.
module peripheral_apb42ahb3_strb_decode
    import peripheral_apb42ahb3_pkg::*;
(
    input  logic [3:0] i_pstrb,
    input  logic       i_pwrite,
    output logic       o_legal,
    output logic [2:0] o_hsize,
    output logic [1:0] o_offset
);

    // Strobe pattern to {legal, size, offset}; anything not naturally aligned is illegal
    always_comb begin
        o_legal  = 1'b0;
        o_hsize  = HSIZE_WORD;
        o_offset = 2'b00;
        if (!i_pwrite) begin
            o_legal = 1'b1;
        end else begin
            case (i_pstrb)
                4'b0001: begin o_legal = 1'b1; o_hsize = HSIZE_BYTE;  o_offset = 2'd0; end
                4'b0010: begin o_legal = 1'b1; o_hsize = HSIZE_BYTE;  o_offset = 2'd1; end
                4'b0100: begin o_legal = 1'b1; o_hsize = HSIZE_BYTE;  o_offset = 2'd2; end
                4'b1000: begin o_legal = 1'b1; o_hsize = HSIZE_BYTE;  o_offset = 2'd3; end
                4'b0011: begin o_legal = 1'b1; o_hsize = HSIZE_HWORD; o_offset = 2'd0; end
                4'b1100: begin o_legal = 1'b1; o_hsize = HSIZE_HWORD; o_offset = 2'd2; end
                4'b1111: begin o_legal = 1'b1; o_hsize = HSIZE_WORD;  o_offset = 2'd0; end
                default: begin o_legal = 1'b0; o_hsize = HSIZE_WORD;  o_offset = 2'd0; end
            endcase
        end
    end

endmodule

// File: rtl/peripheral_apb42ahb3.sv
// APB4 completer that turns each APB transfer into one AHB3-Lite single
// transfer; PREADY is withheld until the AHB data phase has completed.
module peripheral_apb42ahb3
    import peripheral_apb42ahb3_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [2:0]            PPROT,
    input  logic [3:0]            PSTRB,
    input  logic [PADDR_SIZE-1:0] PADDR,
    input  logic [HDATA_SIZE-1:0] PWDATA,
    output logic [HDATA_SIZE-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    state_e                  r_state;
    logic [HDATA_SIZE-1:0]   r_pwdata;
    logic [HDATA_SIZE-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [HADDR_SIZE-1:0]   r_haddr;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic [2:0]              r_hburst;
    logic [3:0]              r_hprot;
    logic [1:0]              r_htrans;
    logic [HDATA_SIZE-1:0]   r_hwdata;

    logic                    w_legal;
    logic [2:0]              w_hsize;
    logic [1:0]              w_offset;
    logic [HADDR_SIZE-1:0]   w_paddr_ext;
    logic                    w_unused_paddr_lsb;

    peripheral_apb42ahb3_strb_decode u_strb_decode (
        .i_pstrb  (PSTRB),
        .i_pwrite (PWRITE),
        .o_legal  (w_legal),
        .o_hsize  (w_hsize),
        .o_offset (w_offset)
    );

    assign w_paddr_ext        = HADDR_SIZE'(PADDR);
    assign w_unused_paddr_lsb = ^w_paddr_ext[1:0];

    // Transfer sequencer: setup capture, AHB address/data phases, one-cycle APB response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_pwdata  <= {HDATA_SIZE{1'b0}};
            r_prdata  <= {HDATA_SIZE{1'b0}};
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_haddr   <= {HADDR_SIZE{1'b0}};
            r_hwrite  <= 1'b0;
            r_hsize   <= HSIZE_BYTE;
            r_hburst  <= HBURST_SINGLE;
            r_hprot   <= 4'b0000;
            r_htrans  <= HTRANS_IDLE;
            r_hwdata  <= {HDATA_SIZE{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_pwdata <= PWDATA;
                        if (w_legal) begin
                            r_htrans <= HTRANS_NONSEQ;
                            r_hburst <= HBURST_SINGLE;
                            r_haddr  <= {w_paddr_ext[HADDR_SIZE-1:2], w_offset};
                            r_hsize  <= w_hsize;
                            r_hwrite <= PWRITE;
                            r_hprot  <= hprot_map(PPROT);
                            r_state  <= ST_ADDR;
                        end else begin
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        if (r_hwrite) begin
                            r_hwdata <= r_pwdata;
                        end
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // An ERROR response's first cycle has HREADY low and is deliberately not acted on
                    if (HREADY) begin
                        if (!r_hwrite) begin
                            r_prdata <= HRDATA;
                        end
                        r_pslverr <= HRESP;
                        r_pready  <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_htrans  <= HTRANS_IDLE;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign PRDATA    = r_prdata;
    assign PREADY    = r_pready;
    assign PSLVERR   = r_pslverr;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = r_hburst;
    assign HPROT     = r_hprot;
    assign HTRANS    = r_htrans;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = r_hwdata;

endmodule

// File: tb/tb_peripheral_apb42ahb3.sv
// Randomized bench for the APB4-to-AHB3-Lite bridge: a cycle-timeline model of
// each transfer predicts every output and a negedge process compares them.
module tb_peripheral_apb42ahb3;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [2:0]  PPROT = 3'b000;
    logic [3:0]  PSTRB = 4'b0000;
    logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: held outputs and per-cycle outputs
    logic [31:0] m_prdata = 32'h0, m_haddr = 32'h0, m_hwdata = 32'h0;
    logic [2:0]  m_hsize = 3'b000;
    logic [3:0]  m_hprot = 4'b0000;
    logic        m_hwrite = 1'b0, m_pready = 1'b0, m_pslverr = 1'b0;
    logic [1:0]  m_htrans = 2'b00;

    // observations of the latest transfer, pinned against literals
    logic [31:0] obs_haddr, obs_prdata, obs_hwdata;
    logic [2:0]  obs_hsize;
    logic [3:0]  obs_hprot;
    logic        obs_pslverr, obs_nonseq;
    int          obs_pready_k;

    peripheral_apb42ahb3 dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PPROT(PPROT), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge HCLK) begin
        chk("PRDATA", PRDATA, m_prdata);
        chk("PREADY", {31'd0, PREADY}, {31'd0, m_pready});
        chk("PSLVERR", {31'd0, PSLVERR}, {31'd0, m_pslverr});
        chk("HADDR", HADDR, m_haddr);
        chk("HWRITE", {31'd0, HWRITE}, {31'd0, m_hwrite});
        chk("HSIZE", {29'd0, HSIZE}, {29'd0, m_hsize});
        chk("HBURST", {29'd0, HBURST}, 32'd0);
        chk("HPROT", {28'd0, HPROT}, {28'd0, m_hprot});
        chk("HTRANS", {30'd0, HTRANS}, {30'd0, m_htrans});
        chk("HMASTLOCK", {31'd0, HMASTLOCK}, 32'd0);
        chk("HWDATA", HWDATA, m_hwdata);
    end

    // Strobe rule from popcount and lowest set bit
    task automatic model_decode(input logic wr, input logic [3:0] strb,
                                output logic legal, output logic [2:0] size, output logic [1:0] off);
        int ones;
        int low;
        ones = $countones(strb);
        low = 0;
        for (int i = 3; i >= 0; i--) if (strb[i]) low = i;
        if (!wr) begin
            legal = 1'b1; size = 3'd2; off = 2'd0;
        end else begin
            legal = (ones == 1) || (ones == 4) || (strb == 4'b0011) || (strb == 4'b1100);
            size  = (ones == 1) ? 3'd0 : (ones == 2) ? 3'd1 : 3'd2;
            off   = (ones == 4) ? 2'd0 : 2'(low);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            m_pready = 1'b0; m_pslverr = 1'b0; m_htrans = 2'b00;
            @(posedge HCLK); #1;
        end
    endtask

    // One APB transfer; called at the start of its setup cycle, returns at the start of the next free cycle
    task automatic run_txn(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] prot, input int wa_in,
                           input int wd_in, input logic err, input logic drop, input int rst_at,
                           input logic [31:0] rdata);
        logic       legal;
        logic [2:0] size;
        logic [1:0] off;
        int wa, wd, len;
        model_decode(wr, strb, legal, size, off);
        wa  = legal ? wa_in : 0;
        wd  = (err && wd_in == 0) ? 1 : wd_in;
        len = legal ? 3 + wa + wd : 1;
        obs_nonseq = 1'b0; obs_pready_k = -1;
        for (int k = 0; k <= len; k++) begin
            PSEL = 1'b1; PENABLE = (k != 0); PWRITE = wr; PSTRB = strb;
            PADDR = addr; PWDATA = wdata; PPROT = prot;
            if (drop && k >= 2) begin PSEL = 1'b0; PENABLE = 1'b0; end
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            if (legal && k >= 1 && k <= 1 + wa) HREADY = (k == 1 + wa);
            if (legal && k >= 2 + wa && k <= 2 + wa + wd) begin
                HREADY = (k == 2 + wa + wd);
                HRESP  = err && (k >= 1 + wa + wd);
                if (k == 2 + wa + wd) HRDATA = rdata;
            end
            m_pready  = (k == len) && (k > 0);
            m_pslverr = (k == len) ? (legal ? err : 1'b1) : 1'b0;
            if (k == len && legal && !wr) m_prdata = rdata;
            if (legal && k == 1) begin
                m_haddr = {addr[31:2], off}; m_hsize = size; m_hwrite = wr;
                m_hprot = {2'b00, prot[0], ~prot[2]};
            end
            m_htrans = (legal && k >= 1 && k <= 1 + wa) ? 2'b10 : 2'b00;
            if (legal && wr && k == 2 + wa) m_hwdata = wdata;
            if (k == rst_at && k > 0) begin
                HRESETn = 1'b0;
                m_prdata = 32'h0; m_haddr = 32'h0; m_hwdata = 32'h0; m_hsize = 3'b000;
                m_hprot = 4'b0000; m_hwrite = 1'b0; m_pready = 1'b0; m_pslverr = 1'b0; m_htrans = 2'b00;
                #1;
                chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
                chk("rst_pready", {31'd0, PREADY}, 32'd0);
                chk("rst_haddr", HADDR, 32'h0);
                chk("rst_hwdata", HWDATA, 32'h0);
                @(negedge HCLK); @(posedge HCLK); #1;
                HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
                return;
            end
            @(negedge HCLK); #1;
            if (HTRANS == 2'b10) obs_nonseq = 1'b1;
            if (k == 1) begin obs_haddr = HADDR; obs_hsize = HSIZE; obs_hprot = HPROT; end
            if (legal && k == 2 + wa) obs_hwdata = HWDATA;
            if (PREADY && obs_pready_k < 0) begin
                obs_pready_k = k; obs_prdata = PRDATA; obs_pslverr = PSLVERR;
            end
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        logic [3:0] legal_strb [7];
        legal_strb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        #12;
        chk("reset_pready", {31'd0, PREADY}, 32'd0);
        chk("reset_htrans", {30'd0, HTRANS}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(2);

        run_txn(1'b0, 4'b0000, 32'h100, 32'h0, 3'b000, 0, 0, 1'b0, 1'b0, 0, 32'hDEADBEEF);
        chk("rd_haddr", obs_haddr, 32'h100);
        chk("rd_hsize", {29'd0, obs_hsize}, 32'd2);
        chk("rd_pready_cycle", obs_pready_k, 32'd3);
        chk("rd_prdata", obs_prdata, 32'hDEADBEEF);
        chk("rd_pslverr", {31'd0, obs_pslverr}, 32'd0);
        idle(1);

        run_txn(1'b1, 4'b0100, 32'h20, 32'h00AB0000, 3'b000, 0, 0, 1'b0, 1'b0, 0, 32'h0);
        chk("wr_haddr", obs_haddr, 32'h22);
        chk("wr_hsize", {29'd0, obs_hsize}, 32'd0);
        chk("wr_hwdata", obs_hwdata, 32'h00AB0000);
        chk("wr_pslverr", {31'd0, obs_pslverr}, 32'd0);
        idle(1);

        run_txn(1'b1, 4'b0101, 32'h40, 32'h12345678, 3'b000, 0, 0, 1'b0, 1'b0, 0, 32'h0);
        chk("ill_nonseq", {31'd0, obs_nonseq}, 32'd0);
        chk("ill_pready_cycle", obs_pready_k, 32'd1);
        chk("ill_pslverr", {31'd0, obs_pslverr}, 32'd1);
        idle(1);

        // two plain DATA waits then a two-cycle ERROR whose first cycle is a third wait
        run_txn(1'b0, 4'b0000, 32'h80, 32'h0, 3'b000, 0, 3, 1'b1, 1'b0, 0, 32'h0BADF00D);
        chk("err_pready_cycle", obs_pready_k, 32'd6);
        chk("err_pslverr", {31'd0, obs_pslverr}, 32'd1);
        idle(1);

        run_txn(1'b1, 4'b1111, 32'hA0, 32'hCAFEF00D, 3'b000, 0, 2, 1'b0, 1'b0, 3, 32'h0);
        idle(1);
        run_txn(1'b0, 4'b0000, 32'hC0, 32'h0, 3'b000, 0, 0, 1'b0, 1'b0, 0, 32'h13572468);
        chk("post_rst_pready_cycle", obs_pready_k, 32'd3);
        chk("post_rst_prdata", obs_prdata, 32'h13572468);
        idle(1);

        run_txn(1'b0, 4'b0000, 32'h200, 32'h0, 3'b101, 0, 0, 1'b0, 1'b0, 0, 32'h11111111);
        chk("b2b1_hprot", {28'd0, obs_hprot}, 32'h2);
        run_txn(1'b0, 4'b0000, 32'h204, 32'h0, 3'b101, 0, 0, 1'b0, 1'b0, 0, 32'h22222222);
        chk("b2b2_hprot", {28'd0, obs_hprot}, 32'h2);
        chk("b2b2_pready_cycle", obs_pready_k, 32'd3);

        for (int t = 0; t < 250; t++) begin
            logic       wr;
            logic [3:0] strb;
            wr   = 1'($urandom_range(0, 1));
            strb = ($urandom_range(0, 3) != 0) ? legal_strb[$urandom_range(0, 6)] : 4'($urandom);
            run_txn(wr, strb, $urandom, $urandom, 3'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    0, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
